// File: rtl/pipelined_array_multiplier.sv
// Pipelined WIDTH x WIDTH array multiplier: each stage folds WIDTH/STAGES
// partial-product rows into a running sum; signed mode uses Baugh-Wooley terms.
module pipelined_array_multiplier #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   P
);

  localparam int PW   = 2 * WIDTH;
  localparam int ROWS = WIDTH / STAGES;
  // Baugh-Wooley correction: +2^WIDTH and +2^(2*WIDTH-1), seeded into the sum.
  localparam logic [PW-1:0] BW_CORR = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

  // Folds ROWS rows into acc; b holds the not-yet-consumed multiplier bits.
  function automatic logic [PW-1:0] add_rows(
    input logic [PW-1:0]    acc,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             sgn,
    input int               base
  );
    logic [PW-1:0] sum;
    logic [PW-1:0] row;
    int            idx;
    sum = acc;
    for (int k = 0; k < ROWS; k++) begin
      idx = base + k;
      row = '0;
      row[WIDTH-1:0] = a & {WIDTH{b[k]}};
      if (sgn) begin
        // Cross terms with exactly one sign bit are complemented.
        if (idx == WIDTH - 1) row[WIDTH-2:0] = ~row[WIDTH-2:0];
        else                  row[WIDTH-1]   = ~row[WIDTH-1];
      end
      sum = sum + (row << idx);
    end
    return sum;
  endfunction

  logic [PW-1:0]    sum_q   [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic             sgn_q   [STAGES];
  logic             valid_q [STAGES];

  assign out_valid = valid_q[STAGES-1];
  assign P         = sum_q[STAGES-1];
  assign in_ready  = ~(out_valid & ~out_ready);

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [PW-1:0]    acc_in;
      logic [PW-1:0]    sum_d;
      logic [WIDTH-1:0] a_in;
      logic [WIDTH-1:0] b_in;
      logic [WIDTH-1:0] b_d;
      logic             sgn_in;
      logic             valid_in;

      if (gi == 0) begin : g_first
        assign acc_in   = is_signed ? BW_CORR : '0;
        assign a_in     = A;
        assign b_in     = B;
        assign sgn_in   = is_signed;
        assign valid_in = in_valid;
      end else begin : g_next
        assign acc_in   = sum_q[gi-1];
        assign a_in     = a_q[gi-1];
        assign b_in     = b_q[gi-1];
        assign sgn_in   = sgn_q[gi-1];
        assign valid_in = valid_q[gi-1];
      end

      assign sum_d = add_rows(acc_in, a_in, b_in, sgn_in, gi * ROWS);
      assign b_d   = b_in >> ROWS;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q[gi] <= 1'b0;
          sum_q[gi]   <= '0;
          a_q[gi]     <= '0;
          b_q[gi]     <= '0;
          sgn_q[gi]   <= 1'b0;
        end else if (in_ready) begin
          valid_q[gi] <= valid_in;
          sum_q[gi]   <= sum_d;
          a_q[gi]     <= a_in;
          b_q[gi]     <= b_d;
          sgn_q[gi]   <= sgn_in;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipelined_array_multiplier.sv
// Scoreboard bench for pipelined_array_multiplier (WIDTH=8, STAGES=4).
module tb_pipelined_array_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] P;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_p = '0;
  logic        rnd_done;

  pipelined_array_multiplier #(.WIDTH(8), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .is_signed(is_signed), .out_valid(out_valid),
    .out_ready(out_ready), .P(P)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer product of the operands interpreted per mode.
  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic sg);
    int x;
    int y;
    x = sg ? int'($signed(a)) : int'(a);
    y = sg ? int'($signed(b)) : int'(b);
    return 16'(x * y);
  endfunction

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sg, input logic [15:0] exp);
    int tries;
    tries = 0;
    A = a; B = b; is_signed = sg; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && tries < 200) begin
      tries++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready=0 after 200 cycles, required 1");
    end else begin
      exp_q.push_back(exp);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_latency(input string name, input int exp_n);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check(name, 32'(n), 32'(exp_n));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_p", 32'(P), 32'(prev_p));
      end
      check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output: got P=0x%04h, required no output", P);
        end else begin
          exp_v = exp_q.pop_front();
          check("product", 32'(P), 32'(exp_v));
          $display("out P=0x%04h exp=0x%04h", P, exp_v);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_p     = P;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    logic       rs;
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; is_signed = 1'b0; out_ready = 1'b1;
    rnd_done = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_p", 32'(P), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // First edge after reset release accepts; 13*11 appears 4 cycles later.
    send(8'd13, 8'd11, 1'b0, 16'h008F);
    wait_latency("latency_13x11", 4);
    idle(3);

    send(8'd255, 8'd255, 1'b0, 16'hFE01);
    send(8'd0,   8'd255, 1'b0, 16'h0000);
    send(8'h80, 8'h80, 1'b1, 16'h4000);
    send(8'hFF, 8'h7F, 1'b1, 16'hFF81);
    send(8'h80, 8'h7F, 1'b1, 16'hC080);
    send(8'hFF, 8'h02, 1'b0, 16'h01FE);
    send(8'hFF, 8'h02, 1'b1, 16'hFFFE);
    send(8'h80, 8'h80, 1'b0, 16'h4000);
    send(8'hFF, 8'hFF, 1'b1, 16'h0001);
    idle(8);

    // Consumer blocked for 10 cycles while 6 transactions are offered.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          ra = 8'(i * 37 + 5); rb = 8'(i * 11 + 200); rs = i[0];
          send(ra, rb, rs, ref_mul(ra, rb, rs));
        end
      end
      begin
        idle(10);
        out_ready = 1'b1;
      end
    join
    idle(8);
    check("stall_drained", 32'(exp_q.size()), 32'd0);

    // Random traffic with random gaps and random consumer back-pressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          idle($urandom_range(0, 2) == 0 ? 1 : 0);
          ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
          if ($urandom_range(0, 9) == 0) ra = 8'h80;
          if ($urandom_range(0, 9) == 0) rb = 8'hFF;
          send(ra, rb, rs, ref_mul(ra, rb, rs));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    idle(30);
    check("random_drained", 32'(exp_q.size()), 32'd0);

    // Reset with three transactions in flight: all of them are discarded.
    for (int i = 0; i < 3; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      send(ra, rb, 1'b0, ref_mul(ra, rb, 1'b0));
    end
    rst = 1'b1;
    #1;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_p", 32'(P), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(6);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    send(8'd3, 8'd5, 1'b0, 16'd15);
    wait_latency("latency_3x5", 4);
    idle(6);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_array_multiplier.md
PIPELINED_ARRAY_MULTIPLIER -- requirements
Module: pipelined_array_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits; legal values 2..32.
REQ-002 SHALL have parameter STAGES, default 4: pipeline register stages; legal values 1..WIDTH; WIDTH SHALL be divisible by STAGES.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operands A, B and is_signed are valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-007 SHALL have port A, input, WIDTH bits: multiplicand.
REQ-008 SHALL have port B, input, WIDTH bits: multiplier.
REQ-009 SHALL have port is_signed, input, 1 bit: 1 selects two's-complement operands, 0 selects unsigned; sampled per transaction.
REQ-010 SHALL have port out_valid, output, 1 bit: P holds a completed product.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts P this cycle.
REQ-012 SHALL have port P, output, 2*WIDTH bits: the product.

Function
REQ-013 SHALL form partial-product row i as A AND replicated B[i]; signed mode SHALL use Baugh-Wooley sign handling (inverted MSB terms plus correction constants).
REQ-014 SHALL accumulate WIDTH/STAGES partial-product rows per pipeline stage with a ripple-carry array; the running sum, remaining B bits, A and mode SHALL be registered between stages.
REQ-015 SHALL produce P equal to A*B, exact in 2*WIDTH bits: unsigned product for is_signed=0, two's-complement product for is_signed=1.
REQ-016 SHALL accept a transaction on any cycle where in_valid and in_ready are both high.
REQ-017 SHALL give a latency of exactly STAGES cycles from acceptance to out_valid when no stall occurs.
REQ-018 SHALL sustain a throughput of one transaction per cycle when out_ready is held high.
REQ-019 SHALL drive in_ready as NOT(out_valid AND NOT out_ready), as combinational logic; when in_ready is low, the whole pipeline SHALL stall and hold every stage register and valid bit.
REQ-020 SHALL hold out_valid and P stable while out_valid is high and out_ready is low.
REQ-021 SHALL carry a per-stage valid bit; bubbles SHALL propagate and SHALL never assert out_valid.
REQ-022 SHALL complete in-flight transactions in order, with none dropped, duplicated or reordered.
REQ-023 SHALL apply a change of is_signed between back-to-back transactions only to its own transaction, with no pipeline flush.
REQ-024 SHALL, at boundary operands 0, all-ones and the most negative value, produce the exact values of REQ-015 with no overflow or wrap beyond 2*WIDTH bits.
REQ-025 SHALL, for STAGES=1, register the product only once, so out_valid follows acceptance by one cycle.

Reset
REQ-026 SHALL, while rst is high, asynchronously clear all stage valid bits, set out_valid to 0 and set P to 0.
REQ-027 SHALL hold in_ready at 1 during reset and after it, because out_valid=0.
REQ-028 SHALL discard every in-flight transaction when rst asserts mid-operation; no out_valid SHALL appear for those transactions after rst releases.
REQ-029 SHALL accept a transaction on the first rising edge after rst deasserts.

Verification (WIDTH=8, STAGES=4)
REQ-030 SHALL cover: unsigned A=13, B=11, out_ready=1 -> out_valid exactly 4 cycles later with P=143 (0x008F).
REQ-031 SHALL cover: unsigned 255*255 and 0*255 on back-to-back cycles -> P=0xFE01 then 0x0000 on consecutive cycles.
REQ-032 SHALL cover: signed -128*-128, -1*127 and -128*127 streamed back to back -> P=0x4000, 0xFF81 and 0xC080 in order.
REQ-033 SHALL cover: mixed-mode stream, unsigned 0xFF*0x02 then signed 0xFF*0x02 -> P=0x01FE then 0xFFFE.
REQ-034 SHALL cover: 6 transactions issued with out_ready held low for 10 cycles, then high -> in_ready drops once out_valid is high, P holds stable, and all 6 products emerge in order with none lost.
REQ-035 SHALL cover: 3 transactions in flight, rst pulsed for 1 cycle -> out_valid=0 and P=0 immediately, no stale output, and a new 3*5 issued afterwards returns 15 after 4 cycles.
